// File: rtl/neuro_vec_pkg.sv
// Shared definitions for the vector load/store path: line geometry, store
// funct codes, the store-unit state encoding and the funct-to-lane-count map.
package neuro_vec_pkg;

    localparam int unsigned LANES  = 16;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned LINE_W = LANES * LANE_W;

    localparam logic [2:0] FUNCT_1LANE  = 3'b000;
    localparam logic [2:0] FUNCT_4LANE  = 3'b001;
    localparam logic [2:0] FUNCT_16LANE = 3'b010;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } vsu_state_e;

    // Zero marks an illegal funct.
    function automatic logic [4:0] funct_lanes(input logic [2:0] funct);
        case (funct)
            FUNCT_1LANE:  return 5'd1;
            FUNCT_4LANE:  return 5'd4;
            FUNCT_16LANE: return 5'd16;
            default:      return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/vsu_lane_buffer.sv
// 16x32 lane capture register for the store unit; presents the packed line
// with every lane at or above the active lane count forced to zero.
module vsu_lane_buffer
    import neuro_vec_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [3:0]        lane_i,
    input  logic [LANE_W-1:0] data_i,
    input  logic [4:0]        n_lanes_i,
    output logic [LINE_W-1:0] line_o
);

    logic [LANE_W-1:0] lane_q [LANES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= '0;
        end else if (clr_i) begin
            for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= '0;
        end else if (we_i) begin
            lane_q[lane_i] <= data_i;
        end
    end

    always_comb begin
        line_o = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (5'(k) < n_lanes_i) line_o[k*LANE_W +: LANE_W] = lane_q[k];
        end
    end

endmodule

// File: rtl/vector_store_unit.sv
// Vector store unit: reads 1/4/16 lanes of a WVR/SVR through the register-file
// read port, packs them into one line and issues a single masked memory write.
module vector_store_unit #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned LANE_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [7:0]                  cmd_a,
    input  logic                        cmd_sel,
    input  logic [ADDR_W-1:0]           cmd_addr,
    output logic                        rf_rd_en,
    output logic                        rf_sel,
    output logic [4:0]                  rf_reg,
    output logic [3:0]                  rf_lane,
    input  logic [LANE_W-1:0]           rf_rd_data,
    output logic                        mem_wvalid,
    input  logic                        mem_wready,
    output logic [ADDR_W-1:0]           mem_waddr,
    output logic [LANES*LANE_W-1:0]     mem_wdata,
    output logic [LANES*LANE_W/8-1:0]   mem_wstrb,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    import neuro_vec_pkg::*;

    localparam int unsigned BYTES_PER_LANE = LANE_W / 8;

    vsu_state_e          state_q, state_d;
    logic [2:0]          funct_q, funct_d;
    logic [4:0]          vs_q, vs_d;
    logic                sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          cap_lane_q, cap_lane_d;
    logic                cap_vld_q, cap_vld_d;
    logic                buf_clr;
    logic [4:0]          n_lanes, n_m1;
    logic                last_lane;
    logic [LANES*LANE_W-1:0]   line;
    logic [LANES*LANE_W/8-1:0] strb;

    assign n_lanes   = funct_lanes(funct_q);
    assign n_m1      = n_lanes - 5'd1;
    assign last_lane = ({1'b0, cnt_q} == n_m1);

    always_comb begin
        state_d    = state_q;
        funct_d    = funct_q;
        vs_d       = vs_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        cap_lane_d = cap_lane_q;
        cap_vld_d  = 1'b0;
        buf_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    funct_d = cmd_a[7:5];
                    vs_d    = cmd_a[4:0];
                    sel_d   = cmd_sel;
                    addr_d  = cmd_addr;
                    cnt_d   = '0;
                    buf_clr = 1'b1;
                    state_d = (funct_lanes(cmd_a[7:5]) != 5'd0) ? READ : ERR;
                end
            end
            READ: begin
                // Data returns next cycle, so the lane index travels with a capture flag.
                cap_vld_d  = 1'b1;
                cap_lane_d = cnt_q;
                if (last_lane) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DRAIN:   state_d = WRITE;
            WRITE:   if (mem_wready) state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            funct_q    <= '0;
            vs_q       <= '0;
            sel_q      <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            cap_lane_q <= '0;
            cap_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct_q    <= funct_d;
            vs_q       <= vs_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            cap_lane_q <= cap_lane_d;
            cap_vld_q  <= cap_vld_d;
        end
    end

    vsu_lane_buffer u_lane_buffer (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (buf_clr),
        .we_i      (cap_vld_q),
        .lane_i    (cap_lane_q),
        .data_i    (rf_rd_data),
        .n_lanes_i (n_lanes),
        .line_o    (line)
    );

    always_comb begin
        strb = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (5'(k) < n_lanes) strb[k*BYTES_PER_LANE +: BYTES_PER_LANE] = '1;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rf_rd_en   = (state_q == READ);
    assign rf_sel     = sel_q;
    assign rf_reg     = vs_q;
    assign rf_lane    = cnt_q;
    assign mem_wvalid = (state_q == WRITE);
    assign mem_waddr  = addr_q;
    assign mem_wdata  = line;
    assign mem_wstrb  = mem_wvalid ? strb : '0;
    assign done       = (state_q == DONE) || (state_q == ERR);
    assign err        = (state_q == ERR);

endmodule

// File: tb/tb_vector_store_unit.sv
// Directed bench for vector_store_unit: register-file responder model plus a
// scoreboard of expected memory writes checked at each handshake.
module tb_vector_store_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_a;
    logic         cmd_sel;
    logic [31:0]  cmd_addr;
    logic         rf_rd_en;
    logic         rf_sel;
    logic [4:0]   rf_reg;
    logic [3:0]   rf_lane;
    logic [31:0]  rf_rd_data;
    logic         mem_wvalid;
    logic         mem_wready;
    logic [31:0]  mem_waddr;
    logic [511:0] mem_wdata;
    logic [63:0]  mem_wstrb;
    logic         busy;
    logic         done;
    logic         err;

    always #5 clk = ~clk;

    vector_store_unit #(.LANES(16), .LANE_W(32), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_sel    (cmd_sel),
        .cmd_addr   (cmd_addr),
        .rf_rd_en   (rf_rd_en),
        .rf_sel     (rf_sel),
        .rf_reg     (rf_reg),
        .rf_lane    (rf_lane),
        .rf_rd_data (rf_rd_data),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Register-file model: data valid one cycle after the read strobe, junk otherwise.
    logic [31:0] rf_mem [2][32][16];
    always @(posedge clk) begin
        rf_rd_data <= rf_rd_en ? rf_mem[rf_sel][rf_reg][rf_lane] : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic [31:0]  addr;
        logic [511:0] data;
        logic [63:0]  strb;
    } wr_t;
    wr_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lanes_of(input logic [2:0] f);
        case (f)
            3'b000:  return 1;
            3'b001:  return 4;
            3'b010:  return 16;
            default: return 0;
        endcase
    endfunction

    task automatic run_cmd(input logic [2:0] funct, input logic [4:0] vs, input logic sel,
                           input logic [31:0] addr, input int stall, input bit hold_valid,
                           input string name);
        int n, rd_cnt, rd_t, wv_cnt, wv_t, hs_cnt, hs_t, done_t;
        bit err_seen;
        wr_t e, got;
        logic [511:0] wd0;
        logic [63:0]  ws0;
        logic [31:0]  wa0;
        n = lanes_of(funct);
        if (n > 0) begin
            e.addr = addr;
            e.data = '0;
            e.strb = '0;
            for (int k = 0; k < n; k++) begin
                e.data[k*32 +: 32] = rf_mem[sel][vs][k];
                e.strb[k*4 +: 4]   = 4'hF;
            end
            sb.push_back(e);
        end
        check({name, ":cmd_ready_idle"}, cmd_ready, 1'b1);
        cmd_valid  = 1'b1;
        cmd_a      = {funct, vs};
        cmd_sel    = sel;
        cmd_addr   = addr;
        mem_wready = (stall == 0);
        rd_cnt = 0; wv_cnt = 0; hs_cnt = 0;
        rd_t = -1; wv_t = -1; hs_t = -1; done_t = -1;
        err_seen = 1'b0;
        wd0 = '0; ws0 = '0; wa0 = '0;
        for (int t = 1; t <= 100 && done_t < 0; t++) begin
            tick();
            if (hold_valid) begin
                cmd_a    = {3'b001, vs ^ 5'h10};
                cmd_sel  = ~sel;
                cmd_addr = ~addr;
            end else begin
                cmd_valid = 1'b0;
            end
            if (rf_rd_en) begin
                rd_cnt++;
                if (rd_t < 0) rd_t = t;
                check({name, ":rf_reg"}, rf_reg, vs);
                check({name, ":rf_sel"}, rf_sel, sel);
            end
            if (mem_wvalid) begin
                wv_cnt++;
                if (wv_t < 0) begin
                    wv_t = t;
                    wd0 = mem_wdata;
                    ws0 = mem_wstrb;
                    wa0 = mem_waddr;
                end else begin
                    check({name, ":wdata_stable"}, mem_wdata, wd0);
                    check({name, ":wstrb_stable"}, mem_wstrb, ws0);
                    check({name, ":waddr_stable"}, mem_waddr, wa0);
                end
                if (wv_cnt > stall) mem_wready = 1'b1;
                if (mem_wready) begin
                    hs_cnt++;
                    hs_t = t;
                    if (sb.size() == 0) begin
                        check({name, ":unexpected_write"}, 1'b1, 1'b0);
                    end else begin
                        got = sb.pop_front();
                        check({name, ":wdata"}, mem_wdata, got.data);
                        check({name, ":wstrb"}, mem_wstrb, got.strb);
                        check({name, ":waddr"}, mem_waddr, got.addr);
                    end
                end
            end
            if (done) begin
                done_t    = t;
                err_seen  = err;
                cmd_valid = 1'b0;
            end
        end
        check({name, ":done_seen"}, done_t >= 0, 1'b1);
        check({name, ":rd_count"}, rd_cnt, n);
        check({name, ":err"}, err_seen, n == 0);
        if (n > 0) begin
            check({name, ":first_rd_t"}, rd_t, 1);
            check({name, ":first_wvalid_t"}, wv_t, n + 2);
            check({name, ":handshakes"}, hs_cnt, 1);
            check({name, ":done_after_hs"}, done_t, hs_t + 1);
            check({name, ":wvalid_cycles"}, wv_cnt, stall + 1);
        end else begin
            check({name, ":no_wvalid"}, wv_cnt, 0);
            check({name, ":err_done_t"}, done_t, 1);
            if (sb.size() != 0) void'(sb.pop_back());
        end
        tick();
        mem_wready = 1'b0;
        check({name, ":done_pulse_end"}, done, 1'b0);
        check({name, ":cmd_ready_back"}, cmd_ready, 1'b1);
    endtask

    initial begin
        int pulses;
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_a      = '0;
        cmd_sel    = 1'b0;
        cmd_addr   = '0;
        mem_wready = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < 32; r++)
                for (int l = 0; l < 16; l++)
                    rf_mem[s][r][l] = $urandom;
        rf_mem[0][1][0] = 32'h1111_1234;
        rf_mem[0][3][0] = 32'h4444_4444;
        rf_mem[0][3][1] = 32'h3333_3333;
        rf_mem[0][3][2] = 32'h2222_2222;
        rf_mem[0][3][3] = 32'h1111_1111;
        for (int l = 0; l < 16; l++) rf_mem[1][1][l] = 32'hFFFF_FFFF;

        tick();
        tick();
        check("rst:cmd_ready", cmd_ready, 1'b1);
        check("rst:busy", busy, 1'b0);
        check("rst:rf_rd_en", rf_rd_en, 1'b0);
        check("rst:mem_wvalid", mem_wvalid, 1'b0);
        check("rst:mem_wdata", mem_wdata, '0);
        check("rst:mem_wstrb", mem_wstrb, '0);
        check("rst:done_err", {done, err}, 2'b00);
        reset = 1'b1;
        tick();

        run_cmd(3'b000, 5'd1, 1'b0, 32'h0000_1000, 0, 1'b0, "one_lane");
        run_cmd(3'b001, 5'd3, 1'b0, 32'h0000_2040, 0, 1'b0, "four_lane");
        run_cmd(3'b010, 5'd1, 1'b1, 32'h0000_3080, 5, 1'b0, "sixteen_stall");
        run_cmd(3'b011, 5'd7, 1'b0, 32'h0000_4000, 0, 1'b0, "illegal_011");
        run_cmd(3'b111, 5'd2, 1'b1, 32'h0000_5000, 0, 1'b0, "illegal_111");

        // Reset in the middle of a 16-lane read.
        cmd_valid  = 1'b1;
        cmd_a      = {3'b010, 5'd4};
        cmd_sel    = 1'b0;
        cmd_addr   = 32'h0000_6000;
        mem_wready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 20 && !(rf_rd_en && rf_lane == 4'd7); k++) tick();
        check("midrst:reached_lane7", {rf_rd_en, rf_lane}, {1'b1, 4'd7});
        reset = 1'b0;
        #1;
        check("midrst:cmd_ready", cmd_ready, 1'b1);
        check("midrst:busy", busy, 1'b0);
        check("midrst:rf_rd_en", rf_rd_en, 1'b0);
        check("midrst:rf_lane_reg", {rf_lane, rf_reg, rf_sel}, '0);
        check("midrst:mem_wvalid", mem_wvalid, 1'b0);
        check("midrst:mem_wdata", mem_wdata, '0);
        check("midrst:mem_wstrb", mem_wstrb, '0);
        check("midrst:done_err", {done, err}, 2'b00);
        tick();
        reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done || mem_wvalid) pulses++;
        end
        check("midrst:no_done_after", pulses, 0);
        mem_wready = 1'b0;

        run_cmd(3'b000, 5'd2, 1'b0, 32'h0000_7000, 0, 1'b0, "after_reset");
        run_cmd(3'b001, 5'd5, 1'b1, 32'h0000_8000, 0, 1'b1, "hold_valid");
        check("end:scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
